// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue and regfile-port bundle for regfile_wb_arbiter.
// The master side is the pipeline; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_wb_valid;
  logic            alu_wb_ready;
  logic [AW-1:0]   alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [AW-1:0]   lsu_wb_rd;
  logic [XLEN-1:0] lsu_wb_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic            stall;
  logic            pc_inc_en;
  logic            reg_rd_wrn;
  logic [AW-1:0]   rd_reg_offset;
  logic [XLEN-1:0] reg_data_in;

  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output issue_valid, issue_rs1, issue_rs2,
    output issue_rd, flush,
    input  alu_wb_ready, lsu_wb_ready,
    input  stall, pc_inc_en,
    input  reg_rd_wrn, rd_reg_offset, reg_data_in
  );

  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  issue_valid, issue_rs1, issue_rs2,
    input  issue_rd, flush,
    output alu_wb_ready, lsu_wb_ready,
    output stall, pc_inc_en,
    output reg_rd_wrn, rd_reg_offset, reg_data_in
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: round-robin ALU/LSU writeback,
// busy scoreboard with RAW/WAW stall, and flush handling.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input logic ck_ref,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    FLUSHING = 1'b1
  } state_t;

  state_t          state;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            last_alu;
  logic            wrn_q;
  logic [AW-1:0]   off_q;
  logic [XLEN-1:0] data_q;

  logic            run;
  logic            alu_rdy;
  logic            lsu_rdy;
  logic            acc;
  logic [AW-1:0]   acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            hazard;
  logic            stall;
  logic            pc_inc;
  logic            set_busy;

  always_comb begin
    run     = rst_n && (state == RUN);
    alu_rdy = 1'b0;
    lsu_rdy = 1'b0;
    if (run) begin
      unique case (1'b1)
        bus.alu_wb_valid && !bus.lsu_wb_valid:
          alu_rdy = 1'b1;
        bus.lsu_wb_valid && !bus.alu_wb_valid:
          lsu_rdy = 1'b1;
        bus.alu_wb_valid && bus.lsu_wb_valid: begin
          alu_rdy = !last_alu;
          lsu_rdy = last_alu;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    acc      = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    unique case (1'b1)
      alu_rdy && bus.alu_wb_valid: begin
        acc      = 1'b1;
        acc_rd   = bus.alu_wb_rd;
        acc_data = bus.alu_wb_data;
      end
      lsu_rdy && bus.lsu_wb_valid: begin
        acc      = 1'b1;
        acc_rd   = bus.lsu_wb_rd;
        acc_data = bus.lsu_wb_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard = busy[bus.issue_rs1]
           | busy[bus.issue_rs2]
           | busy[bus.issue_rd];
    stall  = rst_n
           && ((bus.issue_valid && hazard)
           || (state == FLUSHING));
    pc_inc = rst_n && bus.issue_valid
           && !stall && !bus.flush;
    set_busy = pc_inc && (bus.issue_rd != '0);
  end

  // Clear-on-commit, then flush wipe, then set wins.
  always_comb begin
    busy_nxt = busy;
    if (!wrn_q) busy_nxt[off_q] = 1'b0;
    if (state == FLUSHING) busy_nxt = '0;
    if (set_busy) busy_nxt[bus.issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge ck_ref or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      busy     <= '0;
      last_alu <= 1'b0;
      wrn_q    <= 1'b1;
      off_q    <= '0;
      data_q   <= '0;
    end else begin
      busy  <= busy_nxt;
      wrn_q <= !(acc && (acc_rd != '0));
      if (acc && (acc_rd != '0)) begin
        off_q  <= acc_rd;
        data_q <= acc_data;
      end
      if (acc) last_alu <= alu_rdy;
      unique case (state)
        RUN:      if (bus.flush) state <= FLUSHING;
        FLUSHING: if (!bus.flush) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  assign bus.alu_wb_ready  = alu_rdy;
  assign bus.lsu_wb_ready  = lsu_rdy;
  assign bus.stall         = stall;
  assign bus.pc_inc_en     = pc_inc;
  assign bus.reg_rd_wrn    = wrn_q;
  assign bus.rd_reg_offset = off_q;
  assign bus.reg_data_in   = data_q;

endmodule
